// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - I/O window constants and bus widths for mem_io_responder
package mem_io_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 32;

    localparam logic [1:0]  IO_SEL      = 2'b11;
    localparam logic [17:0] IO_IN_PORT  = 18'h30000;
    localparam logic [17:0] IO_CLK_PORT = 18'h30004;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// rtl/mem_io_responder_byte_fifo.sv - show-ahead byte FIFO; head reads 0x00 when empty
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // a pop frees the slot, so a full FIFO still accepts a simultaneous push
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rptr];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU-side RAM plus I/O window; MEM_IO_RX_EN enables the input FIFO
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic [BYTE_W-1:0] mem_dout,
    input  logic              mem_wr,
    output logic [BYTE_W-1:0] mem_din,
    output logic              rdy_out,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              prog_end
);

    logic [7:0]  ram [2**RAM_ADDR_W];
    logic [31:0] cycle_cnt;
    logic [31:0] snapshot;
    logic        io_sel;
    logic        tx_full;
    logic        tx_empty;
    logic        tx_push;
    logic [7:0]  tx_push_data;
    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        ram_we;
    logic        snap_load;
    logic        end_set;
    logic [7:0]  io_rd_data;
    logic        unused_bits;

    assign io_sel      = (mem_a[17:16] == IO_SEL);
    assign rdy_out     = !tx_full;
    assign tx_valid    = !tx_empty;
    assign unused_bits = ^mem_a[31:18];

    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = mem_dout;
        rx_pop       = 1'b0;
        ram_we       = 1'b0;
        snap_load    = 1'b0;
        end_set      = 1'b0;
        io_rd_data   = 8'h00;
        if (rdy_out) begin
            if (!io_sel) begin
                ram_we = mem_wr;
            end else if (mem_wr) begin
                if (mem_a[17:0] == IO_IN_PORT) begin
                    tx_push = (mem_dout != 8'h00);
                end else if (mem_a[17:0] == IO_CLK_PORT) begin
                    tx_push      = 1'b1;
                    tx_push_data = 8'h00;
                    end_set      = 1'b1;
                end
            end else if (mem_a[17:0] == IO_IN_PORT) begin
                rx_pop     = 1'b1;
                io_rd_data = rx_head;
            end else if (mem_a[17:2] == IO_CLK_PORT[17:2]) begin
                // byte 0 returns the live counter, which is what the snapshot captures
                if (mem_a[1:0] == 2'd0) begin
                    snap_load  = 1'b1;
                    io_rd_data = cycle_cnt[7:0];
                end else begin
                    io_rd_data = snapshot[{mem_a[1:0], 3'b000} +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din   <= 8'h00;
            cycle_cnt <= 32'd0;
            snapshot  <= 32'd0;
            prog_end  <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (rdy_out && !mem_wr) mem_din <= io_sel ? io_rd_data : ram[mem_a[RAM_ADDR_W-1:0]];
            if (snap_load) snapshot <= cycle_cnt;
            if (end_set) prog_end <= 1'b1;
        end
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_ready),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

`ifdef MEM_IO_RX_EN
    logic rx_full;
    logic rx_empty;

    assign rx_ready = !rx_full;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (rx_valid && rx_ready),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );
`else
    logic unused_rx;

    assign rx_ready  = 1'b0;
    assign rx_head   = 8'h00;
    assign unused_rx = ^{rx_data, rx_valid, rx_pop};
`endif

endmodule
